// File: rtl/gen_step_controller.sv
// gen_step_controller
//   Turns raw board push-buttons into clean Life-engine commands and keeps the
//   binary generation count shown on the seven-segment display.
//
//   Ports
//     i_clk, i_reset        system clock; asynchronous active-high reset
//     i_btn_step/run/clear  raw buttons, asynchronous to i_clk
//     i_engine_ack          engine acknowledge for the asserted request
//     o_step_req            ask the engine for one generation
//     o_clear_req           ask the engine to clear the board
//     o_running             auto-step mode active
//     o_generation          saturating generation count, 0..MAX_GEN
//     o_gen_saturated       o_generation == MAX_GEN
//
//   gen_step_debounce (same file) conditions one button: 2-flop synchroniser,
//   stability counter, one-cycle pulse on a debounced press.

module gen_step_debounce #(
  parameter int DB_COUNT = 1000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);
  localparam int CW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_press <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_COUNT - 1)) begin
        // level held long enough: accept it; only a press produces a pulse
        r_level <= r_sync[1];
        r_cnt   <= '0;
        r_press <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;
endmodule

module gen_step_controller #(
  parameter int DB_COUNT   = 1000000,
  parameter int RUN_PERIOD = 25000000,
  parameter int MAX_GEN    = 9999
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_btn_step,
  input  logic        i_btn_run,
  input  logic        i_btn_clear,
  input  logic        i_engine_ack,
  output logic        o_step_req,
  output logic        o_clear_req,
  output logic        o_running,
  output logic [15:0] o_generation,
  output logic        o_gen_saturated
);
  localparam int TW = (RUN_PERIOD > 1) ? $clog2(RUN_PERIOD) : 1;

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_CLEAR} state_t;

  // button index: 0 = step, 1 = run, 2 = clear
  logic [2:0] w_btn;
  logic [2:0] w_press;
  assign w_btn = {i_btn_clear, i_btn_run, i_btn_step};

  for (genvar gi = 0; gi < 3; gi++) begin : g_db
    gen_step_debounce #(.DB_COUNT(DB_COUNT)) u_db (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_btn   (w_btn[gi]),
      .o_press (w_press[gi])
    );
  end

  logic w_step_p, w_run_p, w_clear_p;
  assign w_step_p  = w_press[0];
  assign w_run_p   = w_press[1];
  assign w_clear_p = w_press[2];

  state_t        r_state;
  logic          r_running;
  logic          r_tick;
  logic          r_pending_clear;
  logic          r_step_req;
  logic          r_clear_req;
  logic [15:0]   r_gen;
  logic [TW-1:0] r_timer;
  logic          w_tick;

  // a tick registered just as running drops must not launch a step
  assign w_tick = r_tick & r_running;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_running       <= 1'b0;
      r_tick          <= 1'b0;
      r_pending_clear <= 1'b0;
      r_step_req      <= 1'b0;
      r_clear_req     <= 1'b0;
      r_gen           <= '0;
      r_timer         <= '0;
    end else begin
      // run timer: tick is registered so the first one lands RUN_PERIOD
      // cycles after running rises
      r_tick <= 1'b0;
      if (r_running) begin
        if (r_timer == TW'(RUN_PERIOD - 1)) begin
          r_timer <= '0;
          r_tick  <= 1'b1;
        end else begin
          r_timer <= r_timer + 1'b1;
        end
      end else begin
        r_timer <= '0;
      end

      if (w_run_p) r_running <= ~r_running;

      case (r_state)
        S_IDLE: begin
          if (w_clear_p || r_pending_clear) begin
            r_state         <= S_CLEAR;
            r_clear_req     <= 1'b1;
            r_pending_clear <= 1'b0;
          end else if ((w_step_p && !r_running) || w_tick) begin
            r_state    <= S_STEP;
            r_step_req <= 1'b1;
          end
        end
        S_STEP: begin
          // steps and ticks are dropped here; a clear waits its turn
          if (w_clear_p) r_pending_clear <= 1'b1;
          if (i_engine_ack) begin
            r_state    <= S_IDLE;
            r_step_req <= 1'b0;
            if (r_gen < 16'(MAX_GEN)) r_gen <= r_gen + 1'b1;
          end
        end
        S_CLEAR: begin
          if (i_engine_ack) begin
            // a cleared board also stops auto-stepping (overrides run_p)
            r_state     <= S_IDLE;
            r_clear_req <= 1'b0;
            r_gen       <= '0;
            r_running   <= 1'b0;
            r_timer     <= '0;
            r_tick      <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_step_req      = r_step_req;
  assign o_clear_req     = r_clear_req;
  assign o_running       = r_running;
  assign o_generation    = r_gen;
  assign o_gen_saturated = (r_gen == 16'(MAX_GEN));
endmodule

// File: doc/gen_step_controller.md
Name: gen_step_controller

Overview:
- Input-side counterpart of the seven-segment generation display. It turns raw board push-buttons into clean engine commands and produces the `generation` value that the display driver shows.
- Functions: debounces step, run/pause and clear buttons. Issues step and clear requests to the Life engine over a req/ack handshake. Free-runs steps at a fixed rate in run mode. Maintains a saturating binary generation count.
- Sits between the board buttons and the engine. Its `generation` output feeds the display driver directly.

Parameters:
- DB_COUNT, 1000000: consecutive stable cycles a synchronised button level must hold before the debounced level changes (10 ms at 100 MHz).
- RUN_PERIOD, 25000000: cycles between auto-step ticks in run mode (4 gen/s at 100 MHz).
- MAX_GEN, 9999: saturation value of `generation`; the four-digit display limit.

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- btn_step  in  1  raw step button, asynchronous to clk
- btn_run  in  1  raw run/pause toggle button, asynchronous
- btn_clear  in  1  raw clear-board button, asynchronous
- engine_ack  in  1  engine acknowledge for the currently asserted request
- step_req  out  1  request the engine compute one generation
- clear_req  out  1  request the engine clear the board
- running  out  1  1 = auto-step mode active
- generation  out  16  binary generation count, 0..MAX_GEN
- gen_saturated  out  1  1 when generation == MAX_GEN

Behaviour:
- Reset (async assert): all outputs 0; FSM in IDLE; sync flops, debounced levels, debounce counters, run timer and pending_clear all 0.
- Input conditioning: each button passes through a 2-flop synchroniser, then a per-button debounce counter.
  - Counter clears whenever the synchronised level equals the debounced level.
  - Otherwise it increments. On reaching DB_COUNT-1 the debounced level flips and the counter clears.
  - A debounced 0->1 transition produces a one-cycle pulse (step_p, run_p, clear_p). Releases produce nothing.
  - A button held through reset release gives exactly one pulse, DB_COUNT+2 cycles after reset deasserts.
- Run control:
  - run_p toggles `running` on the next edge.
  - Run timer counts 0..RUN_PERIOD-1 only while running. At the terminal count it raises `tick` for one cycle and wraps to 0.
  - When running is 0 the timer is held at 0. First tick comes RUN_PERIOD cycles after running rises.
- FSM states: IDLE, STEP_REQ, CLEAR_REQ.
  - IDLE: if clear_p or pending_clear -> CLEAR_REQ and pending_clear cleared. Else if (step_p and !running) or tick -> STEP_REQ. Clear has priority over step in the same cycle. step_p is ignored while running.
  - STEP_REQ: step_req = 1, held until engine_ack is sampled 1. In the ack cycle, generation <= min(generation+1, MAX_GEN) and the FSM returns to IDLE, so step_req is low the following cycle.
    - step_p and tick arriving in this state are dropped; there is no queueing.
    - clear_p sets pending_clear.
    - run_p still toggles running.
  - CLEAR_REQ: clear_req = 1, held until engine_ack is sampled 1. In the ack cycle generation <= 0, running <= 0, run timer <= 0, and the FSM returns to IDLE. step_p and tick are dropped in this state.
  - step_req and clear_req are never both 1. engine_ack sampled in IDLE is ignored.
- Latency:
  - Event pulse in cycle N gives the request high in cycle N+1.
  - Ack in cycle M gives the request low and generation updated in cycle M+1.
  - Minimum request high time is 1 cycle, when ack is already high.
- Saturation: at MAX_GEN, steps are still requested and acknowledged, but generation holds and gen_saturated = 1. Clear returns generation to 0 and gen_saturated to 0.
- Reset mid-handshake: requests drop immediately (async). Engine must tolerate an abandoned request.

Test Plan (DB_COUNT=4, RUN_PERIOD=10):
- Reset then idle 20 cycles -> all outputs 0; engine_ack pulses in IDLE have no effect.
- btn_step high 1 cycle, bouncing 3 toggles in 3 cycles, then steady high 10 cycles -> exactly one step_req. Ack after 3 cycles -> generation = 1, step_req low the cycle after ack.
- Press run, engine acks each request after 1 cycle, 35 cycles after running rises -> 3 step_req pulses 10 cycles apart, generation = 3. Press run again -> running = 0, no further requests.
- btn_clear press while step_req outstanding -> step completes (generation +1), clear_req asserts the cycle after returning to IDLE. On ack: generation = 0, running = 0.
- Preload generation to 9998 via repeated steps, issue 2 steps -> generation 9999, gen_saturated = 1, both requests acknowledged.
- Simultaneous step_p and clear_p in IDLE -> clear_req only; step dropped. Reset asserted mid-STEP_REQ -> step_req low the same cycle, FSM in IDLE.
